// File: rtl/fp_pkg.sv
// Shared definitions for the sequential floating-point divider:
// default field widths, exponent bias, saturation word builder and FSM states.
package fp_pkg;

    localparam int FP_EXP_BIT_DEF = 8;
    localparam int FP_MAT_BIT_DEF = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } fp_div_state_e;

    function automatic int fp_bias(input int exp_bit);
        return (32'sd1 <<< (exp_bit - 32'sd1)) - 32'sd1;
    endfunction

    // One bit of the saturated word {sign, all-ones exponent, all-ones mantissa}.
    function automatic logic fp_sat_bit(input int idx, input int exp_bit,
                                        input int mat_bit, input logic sign);
        logic b;
        if (idx == exp_bit + mat_bit) begin
            b = sign;
        end else if (idx < exp_bit + mat_bit) begin
            b = 1'b1;
        end else begin
            b = 1'b0;
        end
        return b;
    endfunction

endpackage

// File: rtl/fp_mant_div_step.sv
// One restoring division step: subtract the divisor when it fits, emit the
// quotient bit and shift the partial remainder left.
module fp_mant_div_step #(
    parameter int W = 9
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);

    logic [W-1:0] diff_s;

    // Compare, conditionally subtract, shift.
    always_comb begin
        q_bit = (rem >= divisor);
        if (q_bit) begin
            diff_s = rem - divisor;
        end else begin
            diff_s = rem;
        end
        rem_next = diff_s << 1'b1;
    end

endmodule

// File: rtl/fp_div_seq.sv
// Iterative FP divider (odata = idataA / idataB), one quotient bit per cycle,
// truncating, no denormals/Inf/NaN, behind a valid/ready handshake.
module fp_div_seq
    import fp_pkg::*;
#(
    parameter int EXP_BIT  = FP_EXP_BIT_DEF,
    parameter int MAT_BIT  = FP_MAT_BIT_DEF,
    parameter int DATA_BIT = EXP_BIT + MAT_BIT + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_BIT-1:0] idataA,
    input  logic [DATA_BIT-1:0] idataB,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_BIT-1:0] odata,
    output logic                div_by_zero
);

    localparam int Q_BITS = MAT_BIT + 2;
    localparam int CNT_W  = $clog2(Q_BITS + 1);
    localparam int E_W    = EXP_BIT + 2;
    localparam int BIAS   = fp_bias(EXP_BIT);

    localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(Q_BITS - 1);
    localparam logic [E_W-1:0]   BIAS_E    = BIAS[E_W-1:0];
    localparam logic [E_W-1:0]   E_ONE     = {{(E_W-1){1'b0}}, 1'b1};

    fp_div_state_e state_r, state_nxt_s;

    logic [CNT_W-1:0]    cnt_r;
    logic [Q_BITS-1:0]   rem_r;
    logic [Q_BITS-1:0]   q_r;
    logic [MAT_BIT:0]    mb_r;
    logic [EXP_BIT-1:0]  ea_r;
    logic [EXP_BIT-1:0]  eb_r;
    logic                sign_r;
    logic                za_r;
    logic                zb_r;
    logic                in_ready_r;
    logic                out_valid_r;
    logic                dbz_r;
    logic [DATA_BIT-1:0] odata_r;

    logic [Q_BITS-1:0]   step_rem_s;
    logic [Q_BITS-1:0]   step_div_s;
    logic [Q_BITS-1:0]   step_rem_nxt_s;
    logic                step_q_s;
    logic                accept_s;
    logic                a_zero_s;
    logic                b_zero_s;
    logic [E_W-1:0]      e_s;
    logic [MAT_BIT-1:0]  mat_s;
    logic [DATA_BIT-1:0] sat_s;
    logic [DATA_BIT-1:0] result_s;
    logic                result_dbz_s;

    assign accept_s = (state_r == IDLE) && in_valid;
    assign a_zero_s = (idataA[DATA_BIT-2 -: EXP_BIT] == {EXP_BIT{1'b0}});
    assign b_zero_s = (idataB[DATA_BIT-2 -: EXP_BIT] == {EXP_BIT{1'b0}});

    // The first step runs straight off the operands in the accepting cycle,
    // later steps run off the latched remainder and divisor.
    always_comb begin
        if (state_r == IDLE) begin
            step_rem_s = {1'b0, 1'b1, idataA[MAT_BIT-1:0]};
            step_div_s = {1'b0, 1'b1, idataB[MAT_BIT-1:0]};
        end else begin
            step_rem_s = rem_r;
            step_div_s = {1'b0, mb_r};
        end
    end

    fp_mant_div_step #(
        .W (Q_BITS)
    ) u_step (
        .rem      (step_rem_s),
        .divisor  (step_div_s),
        .rem_next (step_rem_nxt_s),
        .q_bit    (step_q_s)
    );

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nxt_s = DIV;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DIV: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = NORM;
                end else begin
                    state_nxt_s = DIV;
                end
            end
            NORM: state_nxt_s = DONE;
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Normalisation and special-case priority; e_s is two's complement so
    // underflow shows up as the top bit set.
    always_comb begin
        sat_s = {DATA_BIT{1'b0}};
        for (int i = 0; i < DATA_BIT; i++) begin
            sat_s[i] = fp_sat_bit(i, EXP_BIT, MAT_BIT, sign_r);
        end
        if (q_r[Q_BITS-1]) begin
            mat_s = q_r[Q_BITS-2 -: MAT_BIT];
            e_s   = {2'b00, ea_r} - {2'b00, eb_r} + BIAS_E;
        end else begin
            mat_s = q_r[Q_BITS-3 -: MAT_BIT];
            e_s   = {2'b00, ea_r} - {2'b00, eb_r} + BIAS_E - E_ONE;
        end
        result_dbz_s = 1'b0;
        if (zb_r) begin
            result_s     = sat_s;
            result_dbz_s = 1'b1;
        end else if (za_r) begin
            result_s = {DATA_BIT{1'b0}};
        end else if (e_s[E_W-1] || (e_s == {E_W{1'b0}})) begin
            result_s = {DATA_BIT{1'b0}};
        end else if (e_s[E_W-2]) begin
            result_s = sat_s;
        end else begin
            result_s = {sign_r, e_s[EXP_BIT-1:0], mat_s};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand latch and quotient iteration; a zero dividend carries no sign.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r  <= {CNT_W{1'b0}};
            rem_r  <= {Q_BITS{1'b0}};
            q_r    <= {Q_BITS{1'b0}};
            mb_r   <= {(MAT_BIT+1){1'b0}};
            ea_r   <= {EXP_BIT{1'b0}};
            eb_r   <= {EXP_BIT{1'b0}};
            sign_r <= 1'b0;
            za_r   <= 1'b0;
            zb_r   <= 1'b0;
        end else if (accept_s) begin
            cnt_r  <= CNT_FIRST;
            rem_r  <= step_rem_nxt_s;
            q_r    <= {{(Q_BITS-1){1'b0}}, step_q_s};
            mb_r   <= {1'b1, idataB[MAT_BIT-1:0]};
            ea_r   <= idataA[DATA_BIT-2 -: EXP_BIT];
            eb_r   <= idataB[DATA_BIT-2 -: EXP_BIT];
            sign_r <= a_zero_s ? 1'b0 : (idataA[DATA_BIT-1] ^ idataB[DATA_BIT-1]);
            za_r   <= a_zero_s;
            zb_r   <= b_zero_s;
        end else if (state_r == DIV) begin
            cnt_r <= cnt_r + CNT_ONE;
            rem_r <= step_rem_nxt_s;
            q_r   <= {q_r[Q_BITS-2:0], step_q_s};
        end
    end

    // Registered handshake flags and result, frozen while DONE waits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            odata_r     <= {DATA_BIT{1'b0}};
            dbz_r       <= 1'b0;
        end else begin
            in_ready_r  <= (state_nxt_s == IDLE);
            out_valid_r <= (state_nxt_s == DONE);
            if (state_r == NORM) begin
                odata_r <= result_s;
                dbz_r   <= result_dbz_s;
            end
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign odata       = odata_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_fp_div_seq.sv
// Randomized and directed bench for fp_div_seq against an arithmetic model of
// the truncating FP divide, with latency and handshake tracking.
module tb_fp_div_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] idataA;
    logic [15:0] idataB;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] odata;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;
    bit mon_en = 1'b0;
    bit seen_valid = 1'b0;

    logic [16:0] exp_q[$];
    int          acc_q[$];

    localparam int NDIR = 11;
    logic [15:0] dir_a [NDIR] = '{16'h40C0, 16'h3F80, 16'hBF80, 16'h3F80, 16'h0000, 16'h8000,
                                  16'h0080, 16'h7F00, 16'h7F80, 16'hBF80, 16'h4049};
    logic [15:0] dir_b [NDIR] = '{16'h4040, 16'h4040, 16'h4000, 16'h0000, 16'h4000, 16'h0000,
                                  16'h4000, 16'h3F00, 16'h3F00, 16'h0000, 16'h3FC0};
    logic [16:0] dir_e [NDIR] = '{17'h04000, 17'h03EAA, 17'h0BF00, 17'h17FFF, 17'h00000, 17'h17FFF,
                                  17'h00000, 17'h07F80, 17'h07FFF, 17'h1FFFF, 17'h04006};

    fp_div_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .idataA      (idataA),
        .idataB      (idataB),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .odata       (odata),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Quotient from the value definition: integer ratio of significands
    // scaled to 9 bits, then truncate and range-check the exponent.
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, ma, mb, q, e, mat;
        logic sg;
        ea = int'(a[14:7]);
        eb = int'(b[14:7]);
        ma = 128 + int'(a[6:0]);
        mb = 128 + int'(b[6:0]);
        sg = (ea == 0) ? 1'b0 : (a[15] ^ b[15]);
        if (eb == 0) return {1'b1, sg, 15'h7FFF};
        if (ea == 0) return 17'h00000;
        q = (ma * 256) / mb;
        if (q >= 256) begin
            mat = (q / 2) % 128;
            e   = ea - eb + 127;
        end else begin
            mat = q % 128;
            e   = ea - eb + 126;
        end
        if (e <= 0) return 17'h00000;
        if (e > 255) return {1'b0, sg, 15'h7FFF};
        return {1'b0, sg, 8'(e), 7'(mat)};
    endfunction

    function automatic logic [15:0] rand_op();
        logic [15:0] v;
        int sel;
        v = 16'($urandom);
        sel = $urandom_range(0, 9);
        if (sel == 0) v[14:7] = 8'h00;
        else if (sel == 1) v[14:7] = 8'hFF;
        else if (sel == 2) v[14:7] = 8'h01;
        else if (sel == 3) v[14:7] = 8'h7F;
        return v;
    endfunction

    // Compare process: handshake flags, result and latency on every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() == 0});
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    chk("odata", {16'd0, odata}, {16'd0, exp_q[0][15:0]});
                    chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, exp_q[0][16]});
                    if (!seen_valid) begin
                        chk("latency", edge_n - acc_q[0], 32'd9);
                        seen_valid = 1'b1;
                    end
                end
            end else if (exp_q.size() != 0 && (edge_n - acc_q[0]) >= 9) begin
                chk("late_valid", {31'd0, out_valid}, 32'd1);
            end
            if (!rst_n) begin
                exp_q.delete();
                acc_q.delete();
                seen_valid = 1'b0;
            end else begin
                if (out_valid && out_ready && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    void'(acc_q.pop_front());
                    seen_valid = 1'b0;
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(model(idataA, idataB));
                    acc_q.push_back(edge_n + 1);
                end
            end
        end
    end

    task automatic wait_accept();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) chk("accept_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_valid(output logic [16:0] res);
        bit ok;
        ok = 1'b0;
        res = 17'h00000;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                res = {div_by_zero, odata};
            end
        end
        if (!ok) chk("result_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, output logic [16:0] res);
        @(posedge clk); #1;
        idataA = a; idataB = b; in_valid = 1'b1; out_ready = 1'b1;
        wait_accept();
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(res);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [16:0] res;
        bit drained;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        idataA = 16'h0000; idataB = 16'h0000;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_odata", {16'd0, odata}, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        mon_en = 1'b1;

        for (int i = 0; i < NDIR; i++) begin
            chk($sformatf("model_%0d", i), {15'd0, model(dir_a[i], dir_b[i])}, {15'd0, dir_e[i]});
            do_op(dir_a[i], dir_b[i], res);
            chk($sformatf("dir_%0d", i), {15'd0, res}, {15'd0, dir_e[i]});
        end

        // Backpressure with new operands waiting at the input.
        @(posedge clk); #1;
        idataA = 16'h40C0; idataB = 16'h4040; in_valid = 1'b1; out_ready = 1'b0;
        wait_accept();
        @(posedge clk); #1;
        idataA = 16'h3F80; idataB = 16'h4040;
        wait_valid(res);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("bp_odata", {16'd0, odata}, 32'h4000);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1 in_valid = 1'b0;
        wait_valid(res);
        chk("bp_second", {15'd0, res}, 32'h03EAA);
        @(posedge clk); #1 out_ready = 1'b1;

        // Reset in the middle of a division.
        @(posedge clk); #1;
        idataA = 16'h3F80; idataB = 16'h4040; in_valid = 1'b1;
        wait_accept();
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        do_op(16'h40C0, 16'h4040, res);
        chk("after_abort", {15'd0, res}, 32'h04000);

        // Random operands, random input gaps and random backpressure.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 1) == 1);
            idataA    = rand_op();
            idataB    = rand_op();
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        drained = 1'b0;
        for (int n = 0; n < 40 && !drained; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0) drained = 1'b1;
        end
        chk("drain", {31'd0, drained}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
